// File: rtl/bch_pkg.sv
// Shared types and default (15,7) code constants for the serial BCH codec family.
package bch_pkg;

  typedef enum logic {
    MODE_ENCODE = 1'b0,
    MODE_CHECK  = 1'b1
  } mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int         BCH15_K   = 7;
  localparam int         BCH15_R   = 8;
  localparam logic [7:0] BCH15_GEN = 8'hD1;

endpackage

// File: rtl/bch_serial_codec_if.sv
// Word-level valid/ready bus of the serial BCH codec: input word side and result side.
interface bch_serial_codec_if #(
  parameter int N = 15,
  parameter int R = 8
);
  logic         mode_i;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_data;
  logic [R-1:0] out_syndrome;
  logic         out_error;
  logic         busy;

  modport master (
    output mode_i, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_syndrome, out_error, busy
  );

  modport slave (
    input  mode_i, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_syndrome, out_error, busy
  );
endinterface

// File: rtl/bch_lfsr_step.sv
// One-bit step of the generator-polynomial LFSR, shared by the serial and future bit-parallel codecs.
module bch_lfsr_step
  import bch_pkg::*;
#(
  parameter int            R        = BCH15_R,
  parameter logic [R-1:0]  GEN_MASK = R'(BCH15_GEN)
) (
  input  mode_e          mode,
  input  logic           bit_i,
  input  logic [R-1:0]   rem_in,
  output logic [R-1:0]   rem_out
);

  logic         fb;
  logic [R-1:0] shifted;

  // ENCODE premultiplies by x^R (bit enters at the feedback); CHECK feeds the bit into the LSB.
  always_comb begin
    shifted = rem_in << 1;
    fb      = bit_i ^ rem_in[R-1];
    if (mode == MODE_CHECK) begin
      shifted[0] = bit_i;
      fb         = rem_in[R-1];
    end
    rem_out = shifted ^ (fb ? GEN_MASK : '0);
  end

endmodule

// File: rtl/bch_serial_codec.sv
// Serial BCH codec: one LFSR bit per clock; ENCODE produces parity, CHECK produces c(x) mod g(x).
module bch_serial_codec
  import bch_pkg::*;
#(
  parameter int           K        = BCH15_K,
  parameter int           R        = BCH15_R,
  parameter logic [R-1:0] GEN_MASK = R'(BCH15_GEN)
) (
  input logic              clk,
  input logic              rst_n,
  bch_serial_codec_if.slave bus
);

  localparam int            N       = K + R;
  localparam int            CW      = $clog2(N + 1);
  localparam logic [CW-1:0] CNT_ENC = CW'(K);
  localparam logic [CW-1:0] CNT_CHK = CW'(N);

  state_e        state, state_nxt;
  mode_e         mode_q;
  mode_e         mode_in;
  logic [N-1:0]  shreg, word_q, out_data_q;
  logic [R-1:0]  rem, rem_nxt, syn_q;
  logic [CW-1:0] cnt;
  logic          err_q;
  logic          accept, last;

  bch_lfsr_step #(.R(R), .GEN_MASK(GEN_MASK)) u_step (
    .mode   (mode_q),
    .bit_i  (shreg[N-1]),
    .rem_in (rem),
    .rem_out(rem_nxt)
  );

  assign mode_in = mode_e'(bus.mode_i);
  assign accept  = bus.in_valid && (state == IDLE);
  assign last    = (state == SHIFT) && (cnt == CW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt        = state;
    bus.in_ready     = (state == IDLE);
    bus.busy         = (state != IDLE);
    bus.out_valid    = (state == DONE);
    bus.out_data     = out_data_q;
    bus.out_syndrome = syn_q;
    bus.out_error    = err_q;
    unique case (state)
      IDLE:    if (bus.in_valid)  state_nxt = SHIFT;
      SHIFT:   if (last)          state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  // Datapath: load on accept, shift MSB-first, capture the result on the final bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q     <= MODE_ENCODE;
      shreg      <= '0;
      word_q     <= '0;
      rem        <= '0;
      cnt        <= '0;
      out_data_q <= '0;
      syn_q      <= '0;
      err_q      <= 1'b0;
    end else if (accept) begin
      mode_q <= mode_in;
      word_q <= bus.in_data;
      rem    <= '0;
      if (mode_in == MODE_CHECK) begin
        shreg <= bus.in_data;
        cnt   <= CNT_CHK;
      end else begin
        shreg <= {bus.in_data[K-1:0], {R{1'b0}}};
        cnt   <= CNT_ENC;
      end
    end else if (state == SHIFT) begin
      shreg <= shreg << 1;
      rem   <= rem_nxt;
      cnt   <= cnt - CW'(1);
      if (last) begin
        syn_q      <= rem_nxt;
        err_q      <= (mode_q == MODE_CHECK) && (|rem_nxt);
        out_data_q <= (mode_q == MODE_CHECK) ? word_q : {word_q[K-1:0], rem_nxt};
      end
    end
  end

endmodule

// File: tb/tb_bch_serial_codec.sv
// Bench for bch_serial_codec: long-division reference model, scoreboard and per-cycle result checker.
module tb_bch_serial_codec;
  import bch_pkg::*;

  localparam int           K   = 7;
  localparam int           R   = 8;
  localparam int           N   = K + R;
  localparam logic [R-1:0] GEN = 8'hD1;
  localparam int           NR  = 1000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bch_serial_codec_if #(.N(N), .R(R)) bus ();

  bch_serial_codec #(.K(K), .R(R), .GEN_MASK(GEN)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [N-1:0] data;
    logic [R-1:0] syn;
    logic         err;
    int           lat;
    int           acc;
  } exp_t;

  exp_t q[$];
  int   hold     = 0;
  bit   started  = 1'b0;
  int   hs_cyc   = -1;
  int   last_acc = -1;
  logic [N-1:0] cws [NR];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Remainder of v(x) divided by g(x) = x^R + GEN, by schoolbook long division.
  function automatic logic [R-1:0] poly_mod(input logic [N-1:0] v);
    logic [N-1:0] x;
    logic [N-1:0] g;
    x = v;
    g = N'({1'b1, GEN});
    for (int i = N - 1; i >= R; i--)
      if (x[i]) x = x ^ (g << (i - R));
    return x[R-1:0];
  endfunction

  function automatic exp_t model(input logic mode, input logic [N-1:0] din);
    exp_t e;
    if (mode) begin
      e.data = din;
      e.syn  = poly_mod(din);
      e.err  = (e.syn != '0);
      e.lat  = N;
    end else begin
      e.syn  = poly_mod({din[K-1:0], {R{1'b0}}});
      e.data = {din[K-1:0], e.syn};
      e.err  = 1'b0;
      e.lat  = K;
    end
    e.acc = 0;
    return e;
  endfunction

  task automatic send(input logic mode, input logic [N-1:0] din);
    exp_t e;
    int   waited;
    waited = 0;
    @(negedge clk);
    bus.mode_i   = mode;
    bus.in_data  = din;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.in_ready) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: in_ready=0 after %0d cycles, required 1", waited);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    e        = model(mode, din);
    e.acc    = cyc;
    last_acc = cyc;
    q.push_back(e);
    bus.in_valid = 1'b0;
    bus.mode_i   = ~mode;
    bus.in_data  = N'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", q.size());
      q.delete();
    end
    @(negedge clk);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_in_ready"},  64'(bus.in_ready),     64'(1));
    check({tag, "_out_valid"}, 64'(bus.out_valid),    64'(0));
    check({tag, "_busy"},      64'(bus.busy),         64'(0));
    check({tag, "_out_error"}, 64'(bus.out_error),    64'(0));
    check({tag, "_out_data"},  64'(bus.out_data),     64'(0));
    check({tag, "_out_syn"},   64'(bus.out_syndrome), 64'(0));
  endtask

  // Result checker: compares every cycle out_valid is high and owns out_ready.
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.out_valid) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_result: out_valid=1 with no word outstanding, required 0");
          bus.out_ready = 1'b1;
        end else begin
          if (!started) begin
            check("latency", 64'(cyc - q[0].acc), 64'(q[0].lat));
            started = 1'b1;
          end
          check("out_data",     64'(bus.out_data),     64'(q[0].data));
          check("out_syndrome", 64'(bus.out_syndrome), 64'(q[0].syn));
          check("out_error",    64'(bus.out_error),    64'(q[0].err));
          check("in_ready_done", 64'(bus.in_ready),    64'(0));
          check("busy_done",    64'(bus.busy),         64'(1));
          if (hold > 0) begin
            hold--;
            bus.out_ready = 1'b0;
          end else begin
            bus.out_ready = 1'b1;
            void'(q.pop_front());
            started = 1'b0;
            hs_cyc  = cyc + 1;
          end
        end
      end else begin
        bus.out_ready = 1'b0;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [N-1:0] din;
    exp_t         e;
    bus.in_valid = 1'b0;
    bus.mode_i   = 1'b0;
    bus.in_data  = '0;

    // Model pins against hand-computed values.
    check("model_par_01", 64'(poly_mod({7'h01, 8'h00})), 64'(8'hD1));
    check("model_par_02", 64'(poly_mod({7'h02, 8'h00})), 64'(8'h73));
    check("model_par_03", 64'(poly_mod({7'h03, 8'h00})), 64'(8'hA2));
    e = model(1'b0, 15'h0001);
    check("model_cw_01",  64'(e.data), 64'(15'h01D1));
    check("model_syn_ok", 64'(poly_mod(15'h01D1)), 64'(8'h00));
    check("model_syn_b0", 64'(poly_mod(15'h01D0)), 64'(8'h01));

    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;

    // Directed encode/check words; upper bits of an ENCODE word must be ignored.
    send(1'b0, 15'h0001);
    send(1'b0, 15'h0002);
    send(1'b0, 15'h0003);
    send(1'b0, 15'h7F81);
    send(1'b1, 15'h01D1);
    send(1'b1, 15'h01D0);
    send(1'b1, 15'h0000);
    drain();

    // Backpressure: ten stalled cycles, then the pending word goes in right after the bubble.
    hold = 10;
    send(1'b0, 15'h0055);
    send(1'b1, 15'h1234);
    check("next_accept", 64'(last_acc), 64'(hs_cyc + 1));
    drain();

    // Reset in the middle of a CHECK shift drops the word.
    send(1'b1, 15'h2AAA);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("midreset");
    q.delete();
    started = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);
    send(1'b1, 15'h01D1);
    send(1'b0, 15'h0002);
    drain();

    // Random encode, then check clean and single-bit-corrupted codewords.
    for (int i = 0; i < NR; i++) begin
      din    = N'($urandom);
      e      = model(1'b0, din);
      cws[i] = e.data;
      send(1'b0, din);
    end
    for (int i = 0; i < NR; i++) send(1'b1, cws[i]);
    for (int i = 0; i < NR; i++) begin
      din = cws[i] ^ (N'(1) << $urandom_range(N - 1, 0));
      send(1'b1, din);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
